// File: rtl/cpu_pkg.sv
// Shared types and constants for the program-counter stage.
package cpu_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t RESET_VECTOR_DEFAULT = 16'h0000;

    // Fetch state: RUN fetches normally, HALT freezes PC and RAS.
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with a top pointer and a separate
// saturating count. Overflow overwrites the oldest entry; underflow leaves
// the stack untouched. Both raise a sticky error flag cleared only by rst.
module ras_stack
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  word_t                    push_data_i,
    output word_t                    top_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ptr_q is the next free slot; the top entry sits at ptr_q - 1.
    word_t              mem_q [DEPTH];
    logic [PTR_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               err_q;

    logic               full;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign top_o   = mem_q[ptr_q - PTR_W'(1)];
    assign count_o = count_q;
    assign err_o   = err_q;

    // Entry storage: written on a push, a simultaneous pop takes precedence.
    // NOTE: the storage array has no reset; its contents only matter once count_q says they are valid.
    always_ff @(posedge clk) begin
        if (push_i && !pop_i) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

    // Pointer, count and sticky error bookkeeping.
    // NOTE: all state here uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (pop_i) begin
            if (empty_o) begin
                err_q <= 1'b1;
            end else begin
                ptr_q   <= ptr_q - PTR_W'(1);
                count_q <= count_q - CNT_W'(1);
            end
        end else if (push_i) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (full) begin
                err_q <= 1'b1;
            end else begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: next-PC selection (sequential + branch offset,
// absolute jump, call/return via the RAS) and the RUN/HALT fetch FSM.
module pc_unit
    import cpu_pkg::*;
#(
    parameter word_t RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int    RAS_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        Stall,
    input  logic [WORD_W-1:0]           Branch_Offset,
    input  logic                        Jump_En,
    input  logic [WORD_W-1:0]           Jump_Target,
    input  logic                        Call_En,
    input  logic                        Ret_En,
    input  logic                        Halt_En,
    input  logic                        Resume,
    output logic [WORD_W-1:0]           PC_Out,
    output logic [WORD_W-1:0]           PC_Plus1,
    output logic                        Halted,
    output logic [$clog2(RAS_DEPTH):0]  RAS_Count,
    output logic                        RAS_Err
);

    pc_state_e  state_q, state_d;
    word_t      pc_q, pc_d;
    word_t      pc_plus1;

    logic       ras_push;
    logic       ras_pop;
    word_t      ras_top;
    logic       ras_empty;

    assign pc_plus1 = pc_q + 16'd1;
    assign PC_Out   = pc_q;
    assign PC_Plus1 = pc_plus1;

    ras_stack #(
        .DEPTH       (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_plus1),
        .top_o       (ras_top),
        .count_o     (RAS_Count),
        .empty_o     (ras_empty),
        .err_o       (RAS_Err)
    );

    // State register for the fetch FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: halt from RUN, resume from HALT, both blocked by Stall.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (!Stall) begin
            case (state_q)
                RUN:     if (Halt_En) state_d = HALT;
                HALT:    if (Resume)  state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        Halted = (state_q == HALT);
    end

    // Next-PC selection and RAS push/pop requests, highest priority first.
    always_comb begin
        pc_d     = pc_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (!Stall && state_q == RUN) begin
            if (Halt_En) begin
                pc_d = pc_plus1;
            end else if (Ret_En) begin
                ras_pop = 1'b1;
                pc_d    = ras_empty ? RESET_VECTOR : ras_top;
            end else if (Call_En) begin
                ras_push = 1'b1;
                pc_d     = Jump_Target;
            end else if (Jump_En) begin
                pc_d = Jump_Target;
            end else begin
                pc_d = pc_plus1 + Branch_Offset;
            end
        end
    end

    // PC register; holds via pc_d when stalled or halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
